mem_bridge: RTL

//  Bridges the core's byte-addressed 32-bit load/store/fetch port to a word-aligned synchronous SRAM.

---
 rtl/mem_bridge.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_bridge.sv
// mem_bridge: byte-addressed 32-bit core port to word-aligned synchronous SRAM.
// Accesses with a non-zero byte offset are split into two aligned word accesses.
// Reads are merged little-endian from the two words. Writes go out as two
// byte-enabled word writes. Memory-side outputs depend only on the state and
// the request registers latched at accept time.
module mem_bridge #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high. req_ready is high only while idle. A request
    // presented while busy is neither accepted nor queued, so the core keeps
    // req_valid (and its payload) stable until it is taken. rsp_valid is a
    // single-cycle pulse with no back-pressure.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_we,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE0  = 3'd1,
        S_ISSUE1  = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [MEM_AW-1:0] w0_q, w0_d;
    logic [1:0]        off_q, off_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [MEM_AW-1:0] w1;

    // Address bits above the SRAM range alias and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

    // The second word wraps naturally at the top of the SRAM.
    assign w1 = w0_q + 1'b1;

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_rdata   = rdata_q;
    assign dbg_state_o = state_q;

    // State and request registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            w0_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            w0_q    <= w0_d;
            off_q   <= off_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic, request latching and read-data merging.
    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        off_d   = off_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    w0_d    = req_addr[MEM_AW+1:2];
                    off_d   = req_addr[1:0];
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    state_d = S_ISSUE0;
                end
            end
            S_ISSUE0: begin
                if (off_q != 2'd0) state_d = S_ISSUE1;
                else if (we_q)     state_d = S_RESP;
                else               state_d = S_CAPTURE;
            end
            S_ISSUE1: begin
                // First word's data arrives now (one-cycle SRAM latency).
                if (!we_q) lo_d = mem_rdata;
                state_d = we_q ? S_RESP : S_CAPTURE;
            end
            S_CAPTURE: begin
                // mem_rdata holds the only word (aligned) or the upper word.
                case (off_q)
                    2'd0:    rdata_d = mem_rdata;
                    2'd1:    rdata_d = {mem_rdata[7:0],  lo_q[31:8]};
                    2'd2:    rdata_d = {mem_rdata[15:0], lo_q[31:16]};
                    default: rdata_d = {mem_rdata[23:0], lo_q[31:24]};
                endcase
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // SRAM strobes, address, byte enables and lane-shifted write data.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = w0_q;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        case (state_q)
            S_ISSUE0: begin
                mem_en   = 1'b1;
                mem_addr = w0_q;
                if (we_q) begin
                    mem_we = 1'b1;
                    case (off_q)
                        2'd0: begin
                            mem_be    = 4'b1111;
                            mem_wdata = wdata_q;
                        end
                        2'd1: begin
                            mem_be    = 4'b1110;
                            mem_wdata = {wdata_q[23:0], 8'h00};
                        end
                        2'd2: begin
                            mem_be    = 4'b1100;
                            mem_wdata = {wdata_q[15:0], 16'h0000};
                        end
                        default: begin
                            mem_be    = 4'b1000;
                            mem_wdata = {wdata_q[7:0], 24'h000000};
                        end
                    endcase
                end
            end
            S_ISSUE1: begin
                mem_en   = 1'b1;
                mem_addr = w1;
                if (we_q) begin
                    mem_we = 1'b1;
                    case (off_q)
                        2'd1: begin
                            mem_be    = 4'b0001;
                            mem_wdata = {24'h000000, wdata_q[31:24]};
                        end
                        2'd2: begin
                            mem_be    = 4'b0011;
                            mem_wdata = {16'h0000, wdata_q[31:16]};
                        end
                        2'd3: begin
                            mem_be    = 4'b0111;
                            mem_wdata = {8'h00, wdata_q[31:8]};
                        end
                        default: begin
                            mem_be    = 4'b0000;
                            mem_wdata = 32'h0;
                        end
                    endcase
                end
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

endmodule
